// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   OP_HALT       opcode that stops fetching once accepted by the decoder
//   OP_W          opcode field width; the opcode sits in the instruction MSBs
//   fetch_state_t fetch FSM states
package fetch_pkg;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf: one-entry holding buffer for a prefetched instruction.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load                  capture loadInstr/loadPc, mark full
//   loadInstr, loadPc     instruction word and the address it came from
//   clear                 entry consumed, mark empty
//   full                  entry holds a valid instruction
//   bufInstr, bufPc       stored instruction and address
module fetch_prefetch_buf #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] loadInstr,
  input  logic [ADDR_W-1:0]  loadPc,
  input  logic               clear,
  output logic               full,
  output logic [INSTR_W-1:0] bufInstr,
  output logic [ADDR_W-1:0]  bufPc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      bufInstr <= '0;
      bufPc    <= '0;
    end else if (load) begin
      full     <= 1'b1;
      bufInstr <= loadInstr;
      bufPc    <= loadPc;
    end else if (clear) begin
      full     <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage ahead of the opcode decoder. Reads instructions
// from instruction memory at PC, holds each in IR and offers it to the decoder
// over valid/ready. Fetching stops once a HALT is accepted; start restarts at 0.
// Build option: FETCH_PREFETCH_EN adds a one-deep prefetch (1 instr / 2 cycles).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  begin at PC=0 (honoured in IDLE/HALT only)
//   imem_req, imem_addr    one-cycle read request and its address
//   imem_valid, imem_rdata read response
//   instr_valid            IR offered to decoder
//   instr_ready            decoder accepts IR
//   op_code, instr         IR opcode field / full IR
//   instr_pc               address IR was fetched from
//   halted                 HALT accepted, fetch stopped
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [2:0]         op_code,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);
  fetch_state_t state, nextState;
  logic [ADDR_W-1:0]  pc, irPc;
  logic [INSTR_W-1:0] ir;
  logic opIsHalt, pcClr, pcInc, loadMem;

  assign op_code     = ir[INSTR_W-1 -: OP_W];
  assign opIsHalt    = (op_code == OP_HALT);
  assign instr       = ir;
  assign instr_pc    = irPc;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign imem_addr   = imem_req ? pc : '0;

`ifdef FETCH_PREFETCH_EN
  logic pfPending, pfReq, pfHit, bufFull, loadBuf;
  logic [INSTR_W-1:0] bufInstr;
  logic [ADDR_W-1:0]  bufPc;

  // pc already points past IR, so the next word is requested while IR waits.
  // A HALT in IR suppresses the request so nothing past HALT is ever read.
  assign pfReq = instr_valid && !opIsHalt && !pfPending && !bufFull;
  assign pfHit = instr_valid && pfPending && imem_valid;

  // Outstanding prefetch; if the handshake leaves ISSUE first, WAIT collects it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pfPending <= 1'b0;
    else if (pfReq)
      pfPending <= 1'b1;
    else if (imem_valid && (state == S_WAIT || state == S_ISSUE))
      pfPending <= 1'b0;
  end

  // Data landing together with the handshake bypasses the buffer into IR.
  fetch_prefetch_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) uBuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pfHit && !instr_ready),
    .loadInstr (imem_rdata),
    .loadPc    (pc),
    .clear     (loadBuf),
    .full      (bufFull),
    .bufInstr  (bufInstr),
    .bufPc     (bufPc)
  );
`endif

  always_comb begin
    nextState = state;
    imem_req  = 1'b0;
    pcClr     = 1'b0;
    pcInc     = 1'b0;
    loadMem   = 1'b0;
`ifdef FETCH_PREFETCH_EN
    loadBuf   = 1'b0;
`endif
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pcClr     = 1'b1;
          nextState = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        nextState = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          loadMem   = 1'b1;
          pcInc     = 1'b1;
          nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FETCH_PREFETCH_EN
        imem_req = pfReq;
        pcInc    = pfHit;
        if (instr_ready) begin
          if (opIsHalt)     nextState = S_HALT;
          else if (bufFull) loadBuf   = 1'b1;
          else if (pfHit)   loadMem   = 1'b1;
          else              nextState = S_WAIT;
        end
`else
        if (instr_ready)
          nextState = opIsHalt ? S_HALT : S_FETCH;
`endif
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nextState;
  end

  // pc wraps naturally at 2**ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= '0;
    else if (pcClr) pc <= '0;
    else if (pcInc) pc <= pc + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir   <= '0;
      irPc <= '0;
    end else if (loadMem) begin
      ir   <= imem_rdata;
      irPc <= pc;
    end
`ifdef FETCH_PREFETCH_EN
    else if (loadBuf) begin
      ir   <= bufInstr;
      irPc <= bufPc;
    end
`endif
  end
endmodule
